// File: rtl/uart_tx_serializer_if.sv
// Handshake/config bundle between the UART register block + TX FIFO (master)
// and the transmit serializer (slave).
interface uart_tx_serializer_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 en_i;
  logic [DIV_WIDTH-1:0] clks_per_bit_i;
  logic                 parity_en_i;
  logic                 parity_odd_i;
  logic                 two_stop_i;
  logic                 fifo_empty_i;
  logic [7:0]           fifo_rdata_i;
  logic                 re_o;
  logic                 tx_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output en_i, clks_per_bit_i, parity_en_i, parity_odd_i, two_stop_i,
           fifo_empty_i, fifo_rdata_i,
    input  re_o, tx_o, busy_o, done_o
  );

  modport slave (
    input  en_i, clks_per_bit_i, parity_en_i, parity_odd_i, two_stop_i,
           fifo_empty_i, fifo_rdata_i,
    output re_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops one byte per frame from a combinational-read FIFO
// and shifts start / 8 data (LSB first) / optional parity / 1-2 stop bits out on tx_o.
module uart_tx_serializer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  uart_tx_serializer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_n;
  logic [2:0]           r_idx;
  logic [7:0]           r_shift;
  logic                 r_par;
  logic                 r_pen;
  logic                 r_two;
  logic                 r_stop2;
  logic                 r_tx;
  logic                 r_busy;

  logic                 w_bit_end;
  logic                 w_last;
  logic                 w_pop;
  logic [DIV_WIDTH-1:0] w_n_new;

  assign w_bit_end = (r_cnt == r_n - DIV_WIDTH'(1));
  assign w_last    = (r_state == STOP) && w_bit_end && (!r_two || r_stop2);
  // Pop either from IDLE or on the final stop cycle so frames abut with no gap.
  assign w_pop     = !rst_i && bus.en_i && !bus.fifo_empty_i &&
                     ((r_state == IDLE) || w_last);
  assign w_n_new   = (bus.clks_per_bit_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2)
                                                          : bus.clks_per_bit_i;

  assign bus.re_o   = w_pop;
  assign bus.done_o = w_last;
  assign bus.tx_o   = r_tx;
  assign bus.busy_o = r_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_n     <= DIV_WIDTH'(2);
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_pen   <= 1'b0;
      r_two   <= 1'b0;
      r_stop2 <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else if (w_pop) begin
      // Parity bit is fixed at capture time; later config changes cannot touch it.
      r_state <= START;
      r_cnt   <= '0;
      r_n     <= w_n_new;
      r_idx   <= '0;
      r_shift <= bus.fifo_rdata_i;
      r_par   <= (^bus.fifo_rdata_i) ^ bus.parity_odd_i;
      r_pen   <= bus.parity_en_i;
      r_two   <= bus.two_stop_i;
      r_stop2 <= 1'b0;
      r_tx    <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= r_pen ? PARITY : STOP;
              r_tx    <= r_pen ? r_par : 1'b1;
              r_stop2 <= 1'b0;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= STOP;
            r_tx    <= 1'b1;
            r_stop2 <= 1'b0;
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_bit_end) begin
            r_cnt   <= '0;
            r_stop2 <= 1'b1;
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
